// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host with receive FIFO.
//   ps2_state_e   : controller FSM states
//   FRAME_BITS    : bits in one PS/2 frame (start, 8 data, parity, stop)
//   us_to_cycles  : microseconds to clock cycles at a given clock rate
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_INHIBIT,
    TX_REQ,
    TX_DATA,
    TX_ACK
  } ps2_state_e;

  localparam int unsigned FRAME_BITS = 11;
  // Falling edges sampled after the start bit: 8 data, parity, stop.
  localparam int unsigned RX_EDGES   = FRAME_BITS - 1;
  // Bits the host drives after the start bit: 8 data, parity.
  localparam int unsigned TX_BITS    = FRAME_BITS - 2;

  // Never returns zero so a very slow clock still yields a usable count.
  function automatic int unsigned us_to_cycles(input longint unsigned clk_hz,
                                               input longint unsigned us);
    longint unsigned cyc;
    cyc = (clk_hz * us) / 64'd1_000_000;
    if (cyc == 64'd0) cyc = 64'd1;
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through byte FIFO for received PS/2 scan codes.
//   clk, reset : clock, synchronous active-high reset
//   push       : write push_data (dropped when full unless popping too)
//   pop        : remove the head entry (ignored when empty)
//   rd_data    : head entry, valid while !empty
//   count      : occupancy 0..DEPTH
//   full/empty : registered occupancy flags
module ps2_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // A push into a full FIFO succeeds only when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are meaningless while empty so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/ps2_host_fifo.sv
// PS/2 host controller: receives device frames into a FIFO and sends
// one-byte host commands with the inhibit / request-to-send protocol.
// Optional macro PS2_PARITY_CHECK_EN: when defined, received frames with
// a parity mismatch are rejected; otherwise only a bad stop bit rejects.
//   CLOCK_50, reset        : clock, synchronous active-high reset
//   PS2_CLK, PS2_DAT       : open-drain bus lines (driven 0 or Z)
//   cmd_data/valid/ready   : command byte handshake
//   cmd_done, cmd_error    : one-cycle command completion pulses
//   rx_data/valid/ready    : FIFO read side (first-word-fall-through)
//   rx_count               : FIFO occupancy
//   rx_overflow            : pulse when a received byte is dropped
//   rx_frame_err           : pulse when a received frame is rejected
module ps2_host_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned RX_DEPTH   = 16,
  parameter int unsigned INHIBIT_US = 120,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  inout  logic                        PS2_CLK,
  inout  logic                        PS2_DAT,
  input  logic [7:0]                  cmd_data,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic                        cmd_done,
  output logic                        cmd_error,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        rx_overflow,
  output logic                        rx_frame_err
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(64'(CLK_HZ), 64'(INHIBIT_US));
  localparam int unsigned TIMEOUT_CYC = us_to_cycles(64'(CLK_HZ), 64'(TIMEOUT_US));
  localparam int unsigned TMR_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  ps2_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       rx_shift_q, rx_shift_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cmd_done_q, cmd_done_d;
  logic             cmd_error_q, cmd_error_d;
  logic             frame_err_q, frame_err_d;
  logic             push_q, push_d;
  logic [7:0]       push_data_q, push_data_d;
  logic             overflow_q, overflow_d;

  logic clk_meta_q, clk_sync_q, clk_last_q;
  logic dat_meta_q, dat_sync_q;
  logic clk_fall;
  logic watchdog_hit;
  logic frame_good;

  logic fifo_pop, fifo_full, fifo_empty;

  // Open-drain drivers.
  assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

  // Bus synchronisers; idle bus level is high.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_last_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      clk_last_q <= clk_sync_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign clk_fall     = clk_last_q && !clk_sync_q;
  assign watchdog_hit = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  // rx_shift_q holds {parity, data}; odd parity means an odd number of ones overall.
  assign frame_good   = dat_sync_q && ((^rx_shift_q) || !PAR_CHK);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    clk_oe_d    = clk_oe_q;
    dat_oe_d    = dat_oe_q;
    cmd_done_d  = 1'b0;
    cmd_error_d = 1'b0;
    frame_err_d = 1'b0;
    push_d      = 1'b0;
    push_data_d = push_data_q;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;
        timer_d   = '0;
        bit_cnt_d = '0;
        // A pending command takes priority over a device start bit.
        if (cmd_valid && cmd_ready_q) begin
          tx_shift_d = {~^cmd_data, cmd_data};
          clk_oe_d   = 1'b1;
          state_d    = TX_INHIBIT;
        end else if (clk_fall && !dat_sync_q) begin
          state_d = RX;
        end
      end

      RX: begin
        timer_d = timer_q + TMR_W'(1);
        if (clk_fall) begin
          timer_d = '0;
          if (bit_cnt_q == 4'(RX_EDGES - 1)) begin
            // Current sample is the stop bit.
            state_d = IDLE;
            if (frame_good) begin
              push_d      = 1'b1;
              push_data_d = rx_shift_q[7:0];
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            rx_shift_d = {dat_sync_q, rx_shift_q[8:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end else if (watchdog_hit) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end

      TX_INHIBIT: begin
        clk_oe_d = 1'b1;
        timer_d  = timer_q + TMR_W'(1);
        if (timer_q == TMR_W'(INHIBIT_CYC - 1)) begin
          // Request-to-send: data low, then let the device clock.
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b1;
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = TX_REQ;
        end
      end

      TX_REQ, TX_DATA: begin
        timer_d = timer_q + TMR_W'(1);
        if (clk_fall) begin
          timer_d = '0;
          if (bit_cnt_q == 4'(TX_BITS)) begin
            // Stop bit: release the line and wait for the device ack.
            dat_oe_d = 1'b0;
            state_d  = TX_ACK;
          end else begin
            dat_oe_d   = !tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[8:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            state_d    = TX_DATA;
          end
        end else if (watchdog_hit) begin
          clk_oe_d    = 1'b0;
          dat_oe_d    = 1'b0;
          cmd_error_d = 1'b1;
          state_d     = IDLE;
        end
      end

      TX_ACK: begin
        dat_oe_d = 1'b0;
        timer_d  = timer_q + TMR_W'(1);
        if (clk_fall) begin
          cmd_done_d  = !dat_sync_q;
          cmd_error_d = dat_sync_q;
          state_d     = IDLE;
        end else if (watchdog_hit) begin
          clk_oe_d    = 1'b0;
          cmd_error_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    // Only a push that the FIFO cannot absorb this cycle is an overflow.
    overflow_d  = push_q && fifo_full && !fifo_pop;
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      cmd_done_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_done_q  <= cmd_done_d;
      cmd_error_q <= cmd_error_d;
      frame_err_q <= frame_err_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign fifo_pop = rx_ready && !fifo_empty;

  ps2_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (CLOCK_50),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (fifo_pop),
    .rd_data   (rx_data),
    .count     (rx_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid     = !fifo_empty;
  assign cmd_ready    = cmd_ready_q;
  assign cmd_done     = cmd_done_q;
  assign cmd_error    = cmd_error_q;
  assign rx_overflow  = overflow_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_host_fifo.sv
// Directed bench for ps2_host_fifo: a behavioural PS/2 device on the bus,
// scaled timing (1 MHz clock: 120-cycle inhibit, 2000-cycle watchdog).
module tb_ps2_host_fifo;

  localparam int unsigned CLK_HZ      = 1_000_000;
  localparam int unsigned RX_DEPTH    = 4;
  localparam int unsigned INHIBIT_US  = 120;
  localparam int unsigned TIMEOUT_US  = 2000;
  localparam int          INHIBIT_CYC = 120;
  localparam int          TIMEOUT_CYC = 2000;
  localparam int          H           = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready, cmd_done, cmd_error;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [2:0] rx_count;
  logic       rx_overflow, rx_frame_err;

  wire  ps2_clk, ps2_dat;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  int n_checks = 0;
  int n_errors = 0;
  int n_ferr = 0, n_ovf = 0, n_done = 0, n_err = 0;
  logic [7:0] popped;

  always #5 clk = ~clk;

  ps2_host_fifo #(
    .CLK_HZ     (CLK_HZ),
    .RX_DEPTH   (RX_DEPTH),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .PS2_CLK      (ps2_clk),
    .PS2_DAT      (ps2_dat),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_done     (cmd_done),
    .cmd_error    (cmd_error),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_count     (rx_count),
    .rx_overflow  (rx_overflow),
    .rx_frame_err (rx_frame_err)
  );

  // Pulse counters.
  always @(negedge clk) begin
    if (rx_frame_err) n_ferr++;
    if (rx_overflow)  n_ovf++;
    if (cmd_done)     n_done++;
    if (cmd_error)    n_err++;
  end

  initial begin
    #600_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One device-driven bit; optionally pop the FIFO in the cycle the DUT pushes.
  task automatic dev_bit(input logic b, input logic pop_here);
    @(negedge clk) dev_dat_low = ~b;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b1;
    if (pop_here) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      popped   = rx_data;
      rx_ready = 1'b1;
      @(negedge clk) rx_ready = 1'b0;
      repeat (H - 5) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    dev_clk_low = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                            input logic pop_stop);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) dev_bit(fr[i], pop_stop && (i == 10));
    if (nbits == 11) begin
      @(negedge clk) dev_dat_low = 1'b0;
      repeat (2 * H) @(negedge clk);
    end
  endtask

  task automatic pop_one();
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk) cmd_valid = 1'b0;
  endtask

  // Device side of a host transmission.
  task automatic dev_receive(input logic ack, output logic [7:0] data, output logic par,
                             output logic stop, output int low_cyc);
    int n;
    logic b;
    data = 8'h00; par = 1'b1; stop = 1'b0; low_cyc = 0;
    n = 0;
    while (ps2_clk !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check("inhibit_start", 32'(ps2_clk), 32'd0);
    while (ps2_clk === 1'b0 && low_cyc < 5000) begin @(negedge clk); low_cyc++; end
    check("request_dat_low", 32'(ps2_dat), 32'd0);
    for (int i = 0; i < 11; i++) begin
      repeat (H / 2) @(negedge clk);
      if (i == 10 && ack) dev_dat_low = 1'b1;
      repeat (H - H / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      b = ps2_dat;
      dev_clk_low = 1'b0;
      if (i < 8) data[i] = b;
      else if (i == 8) par = b;
      else if (i == 9) stop = b;
    end
    repeat (3) @(negedge clk);
    dev_dat_low = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic p, s;
    int low, n, f0, o0, d0, e0;
    logic [7:0] exp_q [4];

    reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    check("rst_pulses", 32'({rx_overflow, rx_frame_err, cmd_done, cmd_error}), 32'd0);
    check("rst_lines", 32'({ps2_clk, ps2_dat}), 32'b11);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Good frame 0x1C.
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("rx1c_valid", 32'(rx_valid), 32'd1);
    check("rx1c_data", 32'(rx_data), 32'h1C);
    check("rx1c_count", 32'(rx_count), 32'd1);
    check("rx1c_no_err", 32'(n_ferr), 32'd0);
    pop_one();
    check("rx1c_popped", 32'(rx_count), 32'd0);

    // 0xAA with wrong parity.
    f0 = n_ferr;
    send_frame(8'hAA, 1'b1, 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("badpar_count", 32'(rx_count), 32'd0);
    check("badpar_err", 32'(n_ferr - f0), 32'd1);
`else
    check("badpar_count", 32'(rx_count), 32'd1);
    check("badpar_data", 32'(rx_data), 32'hAA);
    check("badpar_err", 32'(n_ferr - f0), 32'd0);
    pop_one();
`endif

    // Fill, overflow, then simultaneous push/pop on full.
    send_frame(8'h11, 1'b0, 11, 1'b0);
    send_frame(8'h22, 1'b0, 11, 1'b0);
    send_frame(8'h33, 1'b0, 11, 1'b0);
    send_frame(8'h44, 1'b0, 11, 1'b0);
    check("full_count", 32'(rx_count), 32'd4);
    send_frame(8'h55, 1'b0, 11, 1'b0);
    check("ovf_count", 32'(rx_count), 32'd4);
    check("ovf_pulse", 32'(n_ovf), 32'd1);
    check("ovf_head", 32'(rx_data), 32'h11);
    send_frame(8'h66, 1'b0, 11, 1'b1);
    check("pushpop_popped", 32'(popped), 32'h11);
    check("pushpop_count", 32'(rx_count), 32'd4);
    check("pushpop_no_ovf", 32'(n_ovf), 32'd1);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("drain_%0d", i), 32'(rx_data), 32'(exp_q[i]));
      pop_one();
    end
    check("drain_count", 32'(rx_count), 32'd0);
    check("drain_valid", 32'(rx_valid), 32'd0);

    // Command 0xF4 with ack.
    d0 = n_done; e0 = n_err;
    send_cmd(8'hF4);
    check("f4_ready_low", 32'(cmd_ready), 32'd0);
    dev_receive(1'b1, d, p, s, low);
    check("f4_inhibit_len", 32'(low >= INHIBIT_CYC), 32'd1);
    check("f4_bits", 32'(d), 32'hF4);
    check("f4_parity", 32'(p), 32'd0);
    check("f4_stop_released", 32'(s), 32'd1);
    check("f4_done", 32'(n_done - d0), 32'd1);
    check("f4_no_error", 32'(n_err - e0), 32'd0);
    check("f4_ready_back", 32'(cmd_ready), 32'd1);

    // Command 0xFF, device silent.
    d0 = n_done;
    send_cmd(8'hFF);
    n = 0;
    while (ps2_dat !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check("ff_request", 32'(ps2_dat), 32'd0);
    n = 0;
    while (!cmd_error && n < 3000) begin @(negedge clk); n++; end
    check("ff_error", 32'(cmd_error), 32'd1);
    check("ff_timeout_len", 32'(n >= TIMEOUT_CYC - 2 && n <= TIMEOUT_CYC + 2), 32'd1);
    check("ff_released", 32'({ps2_clk, ps2_dat}), 32'b11);
    check("ff_no_done", 32'(n_done - d0), 32'd0);

    // Command in the same cycle as a device start edge.
    d0 = n_done; f0 = n_ferr;
    @(negedge clk) dev_dat_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_data  = 8'hED;
    cmd_valid = 1'b1;
    @(negedge clk) cmd_valid = 1'b0;
    check("race_ready_low", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    dev_receive(1'b1, d, p, s, low);
    check("race_bits", 32'(d), 32'hED);
    check("race_parity", 32'(p), 32'd1);
    check("race_done", 32'(n_done - d0), 32'd1);
    check("race_not_stored", 32'(rx_count), 32'd0);
    check("race_no_ferr", 32'(n_ferr - f0), 32'd0);

    // Reset in the middle of a received frame.
    f0 = n_ferr; o0 = n_ovf;
    send_frame(8'h5A, 1'b0, 4, 1'b0);
    @(negedge clk) reset = 1'b1;
    dev_dat_low = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_count", 32'(rx_count), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    repeat (TIMEOUT_CYC + 100) @(negedge clk);
    check("midrst_no_ferr", 32'(n_ferr - f0), 32'd0);
    send_frame(8'h3C, 1'b0, 11, 1'b0);
    check("after_rst_data", 32'(rx_data), 32'h3C);
    check("after_rst_count", 32'(rx_count), 32'd1);
    check("after_rst_no_ovf", 32'(n_ovf - o0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
